// File: rtl/inst_mem_slave_if.sv
// Request/response bus between an initiator and the instruction memory slave.
// One request and one response channel, each with a valid/ready handshake.
interface inst_mem_slave_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/inst_mem_slave.sv
// Word-addressed memory slave with fixed response latency and a single outstanding transaction.
// state | meaning
// IDLE  | ready for a request
// BUSY  | latency countdown in progress
// RESP  | response presented, waiting for resp_ready
module inst_mem_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    inst_mem_slave_if.slave  bus
);
    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [32:0] LIMIT    = 33'd4 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wen_q;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic [31:0]             off;
    logic                    req_err;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    accept;
    logic                    req_ready;
    logic                    resp_valid;
    logic [31:0]             resp_data;
    logic                    resp_err;

    // Addresses below the base are rejected before the offset is used, so no wrap into range.
    assign off     = bus.req_addr - BASE_ADDR;
    assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                     ({1'b0, off} >= LIMIT);
    assign req_idx = off[DEPTH_LOG2+1:2];
    assign accept  = bus.req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        resp_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_data  = (err_q || wen_q) ? 32'h0 : rdata_q;
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wen_q   <= bus.req_wen;
                err_q   <= req_err;
                rdata_q <= mem_q[req_idx];
            end
        end
    end

    // Writes land on the accept edge and the array is never touched by reset.
    always_ff @(posedge clk_i) begin
        if (accept && bus.req_wen && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_wmask[b]) mem_q[req_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data;
    assign bus.resp_err   = resp_err;
endmodule

// File: tb/tb_inst_mem_slave.sv
// Directed bench for inst_mem_slave: a LATENCY=2 instance driven from a vector table plus
// stall/abort sequences, and a LATENCY=1 instance for back-to-back throughput.
module tb_inst_mem_slave;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_mem_slave_if if0();
    inst_mem_slave_if if1();

    inst_mem_slave #(.LATENCY(2)) u0 (.clk_i(clk), .rst_i(rst0), .bus(if0.slave));
    inst_mem_slave #(.LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst1), .bus(if1.slave));

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Full transaction on the LATENCY=2 instance, checking accept-to-response latency.
    task automatic txn0(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (!if0.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " req_ready"}, 32'(if0.req_ready), 32'd1);
        if0.req_addr  = v.addr;
        if0.req_wen   = v.wen;
        if0.req_wdata = v.wdata;
        if0.req_wmask = v.mask;
        if0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        if0.req_wen   = 1'b0;
        @(negedge clk);
        n = 1;
        while (!if0.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd2);
        chk({nm, " data"}, if0.resp_data, v.exp_data);
        chk({nm, " err"}, 32'(if0.resp_err), 32'(v.exp_err));
        if0.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        int acc_cyc [6];
        vec_t v;

        vecs[0]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0101, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h11AD_33EF, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'h0, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[14] = '{1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 32'h11AD_33EF, 1'b0};
        vecs[15] = '{1'b1, 32'h8000_0001, 32'h0,         4'hF, 32'h0, 1'b1};
        vecs[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[17] = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'b1010, 32'h0, 1'b0};
        vecs[18] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h12FE_560D, 1'b0};

        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_wen = 1'b0;
        if0.req_wdata = '0;   if0.req_wmask = '0; if0.resp_ready = 1'b0;
        if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_wen = 1'b0;
        if1.req_wdata = '0;   if1.req_wmask = '0; if1.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst resp_valid", 32'(if0.resp_valid), 32'd0);
        chk("rst resp_data", if0.resp_data, 32'h0);
        chk("rst resp_err", 32'(if0.resp_err), 32'd0);
        chk("rst1 resp_valid", 32'(if1.resp_valid), 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", 32'(if0.req_ready), 32'd1);
        chk("post-rst1 req_ready", 32'(if1.req_ready), 32'd1);

        for (int i = 0; i < 19; i++) txn0(vecs[i], $sformatf("vec%0d", i));

        // Response stall with noisy request inputs, then accept right after the handshake.
        v = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h11AD_33EF, 1'b0};
        @(negedge clk);
        if0.req_addr = v.addr; if0.req_wen = 1'b0; if0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        if0.req_valid = 1'b1; if0.req_wen = 1'b1;
        if0.req_addr = 32'h8000_0000; if0.req_wdata = 32'hBADB_AD00; if0.req_wmask = 4'hF;
        n = 0;
        @(negedge clk);
        while (!if0.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall resp arrives", 32'(if0.resp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d resp_valid", k), 32'(if0.resp_valid), 32'd1);
            chk($sformatf("stall%0d data", k), if0.resp_data, 32'h11AD_33EF);
            chk($sformatf("stall%0d req_ready", k), 32'(if0.req_ready), 32'd0);
            @(negedge clk);
        end
        if0.req_wen = 1'b0;
        if0.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.resp_ready = 1'b0;
        @(negedge clk);
        chk("post-hs req_ready", 32'(if0.req_ready), 32'd1);
        chk("post-hs resp_valid", 32'(if0.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        @(negedge clk);
        chk("accepted after hs", 32'(if0.req_ready), 32'd0);
        @(negedge clk);
        chk("after-hs resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("after-hs data", if0.resp_data, 32'h12FE_560D);
        if0.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.resp_ready = 1'b0;

        // Reset during BUSY aborts a write whose data already landed.
        @(negedge clk);
        if0.req_addr = 32'h8000_0008; if0.req_wen = 1'b1;
        if0.req_wdata = 32'h0BAD_F00D; if0.req_wmask = 4'hF; if0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        if0.req_wen = 1'b0;
        if0.resp_ready = 1'b1;
        @(negedge clk);
        chk("busy resp_valid", 32'(if0.resp_valid), 32'd0);
        rst0 = 1'b1;
        @(negedge clk);
        chk("abort rst resp_valid", 32'(if0.resp_valid), 32'd0);
        rst0 = 1'b0;
        @(negedge clk);
        chk("abort req_ready", 32'(if0.req_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (if0.resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort no resp", 32'(seen), 32'd0);
        if0.resp_ready = 1'b0;
        txn0('{1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0}, "abort keeps write");

        // LATENCY=1 back-to-back: three writes then three reads, req_valid held high.
        if1.req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n = 0;
            while (!if1.req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            acc_cyc[k] = cyc;
            if (k < 3) begin
                if1.req_wen = 1'b1; if1.req_addr = 32'h8000_0040 + 32'(4 * k);
                if1.req_wdata = 32'h100 + 32'(k); if1.req_wmask = 4'hF;
            end else begin
                if1.req_wen = 1'b0; if1.req_addr = 32'h8000_0040 + 32'(4 * (k - 3));
            end
            @(negedge clk);
            chk($sformatf("b2b%0d resp_valid", k), 32'(if1.resp_valid), 32'd1);
            chk($sformatf("b2b%0d req_ready", k), 32'(if1.req_ready), 32'd0);
            chk($sformatf("b2b%0d data", k), if1.resp_data,
                (k < 3) ? 32'h0 : 32'h100 + 32'(k - 3));
            if (k > 0) chk($sformatf("b2b%0d spacing", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);
        end
        if1.req_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
